// File: rtl/operand_pipe.sv
// operand_pipe: two-stage operand conditioning unit.
// Stage 1 selects one of NUM_IN operands (flagging out-of-range selects),
// stage 2 optionally two's-complement negates it and flags overflow.
// Both stages use valid/ready handshaking with full 1 item/cycle throughput.
module operand_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_IN*WIDTH-1:0] in_data_i,
    input  logic [SEL_W-1:0]        select_i,
    input  logic                    negate_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [WIDTH-1:0]        out_data_o,
    output logic                    out_ovf_o,
    output logic                    out_err_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i
);

    // Most-negative value: the only operand whose negation overflows.
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Unpacked view of the operand bus.
    logic [WIDTH-1:0] operand_w [NUM_IN];

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
            assign operand_w[gi] = in_data_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Stage 1 registers
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_data_q;
    logic             s1_neg_q;
    logic             s1_err_q;
    logic [WIDTH-1:0] s1_data_d;
    logic             s1_err_d;

    // Stage 2 registers (drive the outputs directly)
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q;
    logic             s2_ovf_q;
    logic             s2_err_q;
    logic [WIDTH-1:0] s2_data_d;
    logic             s2_ovf_d;

    // Handshake
    logic s2_adv;
    logic s1_adv;
    logic in_accept;

    assign s2_adv     = !s2_valid_q || out_ready_i;
    assign s1_adv     = s1_valid_q && s2_adv;
    assign in_ready_o = !s1_valid_q || s2_adv;
    assign in_accept  = in_valid_i && in_ready_o;

    // Operand select: out-of-range selects fall back to operand 0 and flag err.
    always_comb begin
        s1_data_d = operand_w[0];
        s1_err_d  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (select_i == SEL_W'(k)) begin
                s1_data_d = operand_w[k];
                s1_err_d  = 1'b0;
            end
        end
    end

    // Conditional negation; negating MIN_NEG wraps back to itself and flags overflow.
    always_comb begin
        s2_data_d = s1_data_q;
        s2_ovf_d  = 1'b0;
        if (s1_neg_q) begin
            s2_data_d = ~s1_data_q + WIDTH'(1);
            s2_ovf_d  = (s1_data_q == MIN_NEG);
        end
    end

    // Stage 1: load on input transfer, otherwise empty out when the item moves on.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_neg_q   <= 1'b0;
            s1_err_q   <= 1'b0;
        end else if (in_accept) begin
            s1_valid_q <= 1'b1;
            s1_data_q  <= s1_data_d;
            s1_neg_q   <= negate_i;
            s1_err_q   <= s1_err_d;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 2: take the stage 1 item whenever the output slot is free or draining.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ovf_q   <= 1'b0;
            s2_err_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s2_data_d;
                s2_ovf_q  <= s2_ovf_d;
                s2_err_q  <= s1_err_q;
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_data_o  = s2_data_q;
    assign out_ovf_o   = s2_ovf_q;
    assign out_err_o   = s2_err_q;

endmodule

// File: tb/tb_operand_pipe.sv
// Testbench for operand_pipe: scoreboard on the default configuration plus
// directed checks on a NUM_IN=3 and a WIDTH=16/NUM_IN=8 instance.
module tb_operand_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance (WIDTH=8, NUM_IN=4)
    logic [31:0] in_data   = '0;
    logic [1:0]  sel       = '0;
    logic        neg       = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_ovf;
    logic        out_err;
    logic        out_valid;
    logic        out_ready = 1'b0;

    operand_pipe #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .select_i(sel),
        .negate_i(neg), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_ovf_o(out_ovf), .out_err_o(out_err),
        .out_valid_o(out_valid), .out_ready_i(out_ready)
    );

    // Illegal-select instance (NUM_IN=3, SEL_W=2)
    logic [23:0] in3_data  = '0;
    logic [1:0]  sel3      = '0;
    logic        neg3      = 1'b0;
    logic        in3_valid = 1'b0;
    logic        in3_ready;
    logic [7:0]  out3_data;
    logic        out3_ovf;
    logic        out3_err;
    logic        out3_valid;
    logic        out3_ready = 1'b1;

    operand_pipe #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .in_data_i(in3_data), .select_i(sel3),
        .negate_i(neg3), .in_valid_i(in3_valid), .in_ready_o(in3_ready),
        .out_data_o(out3_data), .out_ovf_o(out3_ovf), .out_err_o(out3_err),
        .out_valid_o(out3_valid), .out_ready_i(out3_ready)
    );

    // Wide instance (WIDTH=16, NUM_IN=8, SEL_W=3)
    logic [127:0] in16_data  = '0;
    logic [2:0]   sel16      = '0;
    logic         neg16      = 1'b0;
    logic         in16_valid = 1'b0;
    logic         in16_ready;
    logic [15:0]  out16_data;
    logic         out16_ovf;
    logic         out16_err;
    logic         out16_valid;
    logic         out16_ready = 1'b1;

    operand_pipe #(.WIDTH(16), .NUM_IN(8), .SEL_W(3)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .in_data_i(in16_data), .select_i(sel16),
        .negate_i(neg16), .in_valid_i(in16_valid), .in_ready_o(in16_ready),
        .out_data_o(out16_data), .out_ovf_o(out16_ovf), .out_err_o(out16_err),
        .out_valid_o(out16_valid), .out_ready_i(out16_ready)
    );

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic [9:0] sb_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=0x%0h", tag, got);
        end
    endtask

    // Reference for the default instance: {err, ovf, data}
    function automatic logic [9:0] model(input logic [31:0] ops, input logic [1:0] s, input logic n);
        logic [7:0] x;
        logic [7:0] r;
        logic       o;
        x = ops[s*8 +: 8];
        if (n) begin
            r = 8'(9'h100 - {1'b0, x});
            o = (x == 8'h80);
        end else begin
            r = x;
            o = 1'b0;
        end
        return {1'b0, o, r};
    endfunction

    // Scoreboard: handshakes seen at the negedge complete on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                logic [9:0] e;
                e = sb_q.pop_front();
                check_eq("sb_data", 32'(out_data), 32'(e[7:0]));
                check_eq("sb_ovf", 32'(out_ovf), 32'(e[8]));
                check_eq("sb_err", 32'(out_err), 32'(e[9]));
            end
            pops++;
        end
        if (!rst && in_valid && in_ready)
            sb_q.push_back(model(in_data, sel, neg));
    end

    // Drive one item (called at posedge+1) and hold it until accepted.
    task automatic send_item(input logic [31:0] ops, input logic [1:0] s, input logic n,
                             output int waited);
        in_data  = ops;
        sel      = s;
        neg      = n;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 200)
            check_eq("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int w;
        int p0;
        int t0;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);
        check_eq("rst_out_err", 32'(out_err), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Basic negate and pass-through; operands {0x05,0x11,0x00,0x80}
        out_ready = 1'b1;
        send_item(32'h8000_1105, 2'd0, 1'b1, w);
        // Item is in S1 after its acceptance edge, in S2 after the next edge.
        check_eq("lat_s1_only", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check_eq("lat_valid", 32'(out_valid), 32'd1);
        check_eq("lat_data", 32'(out_data), 32'hFB);
        send_item(32'h8000_1105, 2'd2, 1'b1, w);
        send_item(32'h8000_1105, 2'd3, 1'b1, w);
        send_item(32'h8000_1105, 2'd1, 1'b0, w);
        repeat (3) @(posedge clk);
        #1;

        // Streaming: 16 back-to-back items, one accepted per edge
        p0 = pops;
        t0 = 0;
        for (int i = 0; i < 16; i++) begin
            send_item(32'($urandom()), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), w);
            t0 += w;
        end
        check_eq("stream_no_wait", 32'(t0), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("stream_pops", 32'(pops - p0), 32'd16);

        // Back-pressure: only two items fit
        out_ready = 1'b0;
        send_item(32'h8000_1105, 2'd0, 1'b1, w);   // A -> 0xFB
        send_item(32'h8000_1105, 2'd1, 1'b1, w);   // B -> 0xEF
        in_data  = 32'h8000_1105;
        sel      = 2'd3;
        neg      = 1'b1;
        in_valid = 1'b1;                            // C -> 0x80 ovf
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_hold_data", 32'(out_data), 32'hFB);
            check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        p0 = pops;
        out_ready = 1'b1;
        send_item(32'h8000_1105, 2'd3, 1'b1, w);
        repeat (2) @(posedge clk);
        #1;
        check_eq("bp_drain_pops", 32'(pops - p0), 32'd3);
        check_eq("bp_drain_empty", 32'(sb_q.size()), 32'd0);

        // Reset mid-stream with two items in flight
        out_ready = 1'b0;
        send_item(32'h1234_5678, 2'd1, 1'b1, w);
        send_item(32'h1234_5678, 2'd2, 1'b0, w);
        check_eq("rst2_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst2_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst2_out_data", 32'(out_data), 32'd0);
        check_eq("rst2_in_ready", 32'(in_ready), 32'd1);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst2_no_stale", 32'(out_valid), 32'd0);
        end
        send_item(32'h0000_0007, 2'd0, 1'b1, w);    // -> 0xF9 via scoreboard
        repeat (3) @(posedge clk);
        #1;

        // Illegal select on the NUM_IN=3 instance
        in3_data  = 24'h33_22_01;
        sel3      = 2'd3;
        neg3      = 1'b1;
        in3_valid = 1'b1;
        check_eq("err_in_ready", 32'(in3_ready), 32'd1);
        @(posedge clk);
        #1;
        sel3 = 2'd1;
        neg3 = 1'b0;
        @(posedge clk);
        #1;
        in3_valid = 1'b0;
        check_eq("err_valid", 32'(out3_valid), 32'd1);
        check_eq("err_data", 32'(out3_data), 32'hFF);
        check_eq("err_flag", 32'(out3_err), 32'd1);
        check_eq("err_ovf", 32'(out3_ovf), 32'd0);
        @(posedge clk);
        #1;
        check_eq("legal_valid", 32'(out3_valid), 32'd1);
        check_eq("legal_data", 32'(out3_data), 32'h22);
        check_eq("legal_err", 32'(out3_err), 32'd0);

        // Width scaling on the WIDTH=16 instance
        in16_data         = '0;
        in16_data[127:112] = 16'h8000;
        sel16      = 3'd7;
        neg16      = 1'b1;
        in16_valid = 1'b1;
        @(posedge clk);
        #1;
        in16_data[127:112] = 16'h0001;
        @(posedge clk);
        #1;
        in16_valid = 1'b0;
        check_eq("w16_min_valid", 32'(out16_valid), 32'd1);
        check_eq("w16_min_data", 32'(out16_data), 32'h8000);
        check_eq("w16_min_ovf", 32'(out16_ovf), 32'd1);
        @(posedge clk);
        #1;
        check_eq("w16_one_data", 32'(out16_data), 32'hFFFF);
        check_eq("w16_one_ovf", 32'(out16_ovf), 32'd0);
        check_eq("w16_one_err", 32'(out16_err), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check_eq("sb_final_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
